// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, flag bit positions and
// controller states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LD  = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_NOT = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_XOR = 4'h7,
        OP_SHL = 4'h8,
        OP_SHR = 4'h9,
        OP_MUL = 4'hA
    } alu_op_e;

    // Bit positions inside the stored {C,V,Z,N} flag word.
    localparam int FLG_C = 3;
    localparam int FLG_V = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DONE
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports: start loads a/b; busy while stepping; done marks the final step;
// product holds the full 2*WIDTH result once busy drops.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    // High during the cycle that consumes the last multiplier bit.
    assign done    = busy_q & (cnt_q == CW'(WIDTH - 1));
    assign busy    = busy_q;
    assign product = prod_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, a};
            prod_q   <= '0;
            mplier_q <= b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                prod_q <= prod_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready on both sides, stored flags
// and a multi-cycle multiply.
// Ports: in_valid/in_ready/op/in_a/in_b/ci/ci_sel on the issue side;
// out_valid/out_ready/result/co/ov/zf/nf on the result side; flags_q={C,V,Z,N}.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             ci,
    input  logic             ci_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             ov,
    output logic             zf,
    output logic             nf,
    output logic [3:0]       flags_q
);

    localparam int SW = $clog2(WIDTH);

    alu_state_e state_q, state_d;
    alu_op_e    op_e;

    logic             accept;
    logic             is_mul;
    logic             cin;
    logic [SW-1:0]    sh;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH:0]   shl_ext;

    logic [WIDTH-1:0] d_res;
    logic             d_co;
    logic             d_ov;
    logic             d_upd;

    logic             mul_busy;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic             load;
    logic [WIDTH-1:0] l_res;
    logic             l_co;
    logic             l_ov;
    logic             l_upd;

    assign op_e   = alu_op_e'(op);
    assign accept = in_valid & in_ready;
    assign is_mul = MUL_EN && (op_e == OP_MUL);
    assign cin    = ci_sel ? flags_q[FLG_C] : ci;
    assign sh     = in_b[SW-1:0];

    assign in_ready = rst_n & (state_q == ST_IDLE) & ~mul_busy
                    & (~out_valid | out_ready);

    assign sum = {1'b0, in_a} + {1'b0, in_b}
               + {{WIDTH{1'b0}}, cin};
    assign dif = {1'b0, in_a} - {1'b0, in_b}
               - {{WIDTH{1'b0}}, cin};
    // Bit WIDTH of the widened shift is the last bit pushed out.
    assign shl_ext = {1'b0, in_a} << sh;

    always_comb begin
        d_res = in_b;
        d_co  = 1'b0;
        d_ov  = 1'b0;
        d_upd = 1'b1;
        unique case (op_e)
            OP_LD:  d_res = in_b;
            OP_ADD: begin
                d_res = sum[WIDTH-1:0];
                d_co  = sum[WIDTH];
                d_ov  = (in_a[WIDTH-1] == in_b[WIDTH-1])
                      & (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                d_res = dif[WIDTH-1:0];
                d_co  = dif[WIDTH];
                d_ov  = (in_a[WIDTH-1] != in_b[WIDTH-1])
                      & (dif[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_NOT: d_res = ~in_a;
            OP_AND: d_res = in_a & in_b;
            OP_OR:  d_res = in_a | in_b;
            OP_XOR: d_res = in_a ^ in_b;
            OP_SHL: begin
                d_res = shl_ext[WIDTH-1:0];
                d_co  = shl_ext[WIDTH];
            end
            OP_SHR: d_res = in_a >> sh;
            // Multiplier disabled or NOP/reserved: pass B, keep flags.
            default: d_upd = 1'b0;
        endcase
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept & is_mul),
        .a       (in_a),
        .b       (in_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept && is_mul) state_d = ST_MUL;
            ST_MUL:  if (mul_done) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Output register is fed either by the one-cycle decode or by the
    // finished multiply in DONE; both never coincide since in_ready=0
    // outside IDLE.
    always_comb begin
        load  = (accept & ~is_mul) | (state_q == ST_DONE);
        l_res = d_res;
        l_co  = d_co;
        l_ov  = d_ov;
        l_upd = d_upd;
        if (state_q == ST_DONE) begin
            l_res = mul_prod[WIDTH-1:0];
            l_co  = |mul_prod[2*WIDTH-1:WIDTH];
            l_ov  = |mul_prod[2*WIDTH-1:WIDTH];
            l_upd = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            co        <= 1'b0;
            ov        <= 1'b0;
            zf        <= 1'b0;
            nf        <= 1'b0;
            flags_q   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            result    <= l_res;
            co        <= l_co;
            ov        <= l_ov;
            zf        <= (l_res == '0);
            nf        <= l_res[WIDTH-1];
            if (l_upd) begin
                flags_q <= {l_co, l_ov, (l_res == '0), l_res[WIDTH-1]};
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8 and WIDTH=16.
// Expected values are hand-computed constants.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 8-bit instance
    logic       iv8 = 0, ir8, ci8 = 0, cs8 = 0, ov8o, or8 = 1;
    logic [3:0] op8 = 0;
    logic [7:0] a8 = 0, b8 = 0, r8;
    logic       co8, vf8, zf8, nf8;
    logic [3:0] fl8;

    // 16-bit instance
    logic        iv16 = 0, ir16, ov16o, or16 = 1;
    logic [3:0]  op16 = 0;
    logic [15:0] a16 = 0, b16 = 0, r16;
    logic        co16, vf16, zf16, nf16;
    logic [3:0]  fl16;

    alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .op(op8), .in_a(a8), .in_b(b8),
        .ci(ci8), .ci_sel(cs8),
        .out_valid(ov8o), .out_ready(or8),
        .result(r8), .co(co8), .ov(vf8),
        .zf(zf8), .nf(nf8), .flags_q(fl8)
    );

    alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) u16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16),
        .op(op16), .in_a(a16), .in_b(b16),
        .ci(1'b0), .ci_sel(1'b0),
        .out_valid(ov16o), .out_ready(or16),
        .result(r16), .co(co16), .ov(vf16),
        .zf(zf16), .nf(nf16), .flags_q(fl16)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv8(input logic [3:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic c,
                        input logic s);
        op8 = o; a8 = a; b8 = b; ci8 = c; cs8 = s; iv8 = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic [3:0]  t_op [10];
    logic [15:0] t_a  [10];
    logic [15:0] t_b  [10];
    logic [15:0] t_r  [10];

    initial begin
        int n;
        int hits;
        logic rdy_seen;

        t_op = '{OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR,
                 OP_XOR, OP_NOT, OP_SHR, OP_SHL, OP_LD};
        t_a  = '{16'h0000, 16'h1111, 16'h5000, 16'hF0F0, 16'hF0F0,
                 16'hAAAA, 16'h00FF, 16'h8000, 16'h0001, 16'h0000};
        t_b  = '{16'h1234, 16'h2222, 16'h0001, 16'hFF00, 16'h0F00,
                 16'hFFFF, 16'h0000, 16'h0004, 16'h000F, 16'hBEEF};
        t_r  = '{16'h1234, 16'h3333, 16'h4FFF, 16'hF000, 16'hFFF0,
                 16'h5555, 16'hFF00, 16'h0800, 16'h8000, 16'hBEEF};

        // reset state
        tick(); tick();
        chk("rst_ready", ir8, 0);
        chk("rst_valid", ov8o, 0);
        chk("rst_result", r8, 0);
        chk("rst_flags", fl8, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", ir8, 1);

        // ADD overflow into sign bit
        drv8(OP_ADD, 8'h7F, 8'h01, 0, 0);
        tick();
        iv8 = 0;
        chk("add_valid", ov8o, 1);
        chk("add_res", r8, 8'h80);
        chk("add_cvzn", {co8, vf8, zf8, nf8}, 4'b0101);
        chk("add_flags", fl8, 4'b0101);

        // SUB borrow then chained ADD using stored C
        drv8(OP_SUB, 8'h00, 8'h01, 0, 0);
        tick();
        chk("sub_res", r8, 8'hFF);
        chk("sub_co", co8, 1);
        chk("sub_flags", fl8, 4'b1001);
        drv8(OP_ADD, 8'h00, 8'h00, 0, 1);
        tick();
        iv8 = 0;
        chk("chain_res", r8, 8'h01);
        chk("chain_flags", fl8, 4'b0000);
        tick();
        chk("chain_retired", ov8o, 0);

        // MUL latency and in_ready held low
        drv8(OP_MUL, 8'h10, 8'h20, 0, 0);
        tick();
        iv8 = 0;
        n = 0;
        rdy_seen = 0;
        while (!ov8o && n < 20) begin
            if (ir8) rdy_seen = 1;
            tick();
            n++;
        end
        chk("mul_latency", n, 9);
        chk("mul_ready_low", rdy_seen, 0);
        chk("mul_res", r8, 8'h00);
        chk("mul_cvzn", {co8, vf8, zf8, nf8}, 4'b1110);
        chk("mul_flags", fl8, 4'b1110);
        tick();
        chk("mul_retired", ov8o, 0);

        // output stall holds result and blocks issue
        or8 = 0;
        drv8(OP_ADD, 8'h03, 8'h04, 0, 0);
        tick();
        chk("stall_first", r8, 8'h07);
        drv8(OP_ADD, 8'hF0, 8'h20, 0, 0);
        hits = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (r8 !== 8'h07 || ir8 !== 1'b0 || ov8o !== 1'b1)
                hits++;
        end
        chk("stall_hold", hits, 0);
        or8 = 1;
        #1;
        chk("stall_release_rdy", ir8, 1);
        tick();
        iv8 = 0;
        chk("stall_next_res", r8, 8'h10);
        chk("stall_next_flags", fl8, 4'b1000);
        tick();
        chk("stall_retired", ov8o, 0);

        // reset in the middle of a multiply
        drv8(OP_MUL, 8'h03, 8'h05, 0, 0);
        tick();
        iv8 = 0;
        tick(); tick(); tick();
        rst_n = 0;
        #1;
        chk("midrst_valid", ov8o, 0);
        chk("midrst_flags", fl8, 0);
        chk("midrst_ready", ir8, 0);
        tick();
        rst_n = 1;
        drv8(OP_ADD, 8'h01, 8'h01, 0, 0);
        tick();
        iv8 = 0;
        chk("midrst_add", r8, 8'h02);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ov8o) hits++;
        end
        chk("midrst_no_stale", hits, 0);

        // WIDTH=16 shift with carry-out
        op16 = OP_SHL; a16 = 16'h8001; b16 = 16'h0001; iv16 = 1;
        tick();
        chk("w16_shl_res", r16, 16'h0002);
        chk("w16_shl_co", co16, 1);
        chk("w16_shl_flags", fl16, 4'b1000);

        // reserved opcode keeps flags
        op16 = 4'hF; a16 = 16'h0000; b16 = 16'h0000;
        tick();
        chk("w16_rsv_res", r16, 16'h0000);
        chk("w16_rsv_zf", zf16, 1);
        chk("w16_rsv_flags", fl16, 4'b1000);

        // back-to-back stream, one result per cycle
        for (int i = 0; i < 10; i++) begin
            op16 = t_op[i]; a16 = t_a[i]; b16 = t_b[i];
            tick();
            chk($sformatf("b2b_valid%0d", i), ov16o, 1);
            chk($sformatf("b2b_res%0d", i), r16, t_r[i]);
        end
        iv16 = 0;
        tick();
        chk("b2b_drain", ov16o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
